// File: rtl/il_seq_pkg.sv
// il_seq_pkg: shared command encoding, FSM states and default widths for the step sequencer
package il_seq_pkg;
  localparam int CNT_W_DEF = 32;
  localparam int LAG_W_DEF = 3;
  localparam logic [1:0] OP_STOP = 2'b00;
  localparam logic [1:0] OP_RUN = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_RUN_TO = 2'b11;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STEP, S_TRAIL} state_t;
endpackage

// File: rtl/il_dom_trail.sv
// il_dom_trail: per-domain trailing clock-enable down-counter loaded at halt
module il_dom_trail
  import il_seq_pkg::*;
#(
  parameter int LAG_W = LAG_W_DEF
) (
  input  logic             sys_clk,
  input  logic             sys_reset,
  input  logic             load,
  input  logic [LAG_W-1:0] val,
  output logic             trail_active,
  output logic             pending
);
  logic [LAG_W-1:0] cnt;
  assign pending = cnt != '0;
  assign trail_active = load ? val != '0 : pending;
  // The halt cycle itself issues the first trail enable, so the counter holds the cycles still owed after it
  always_ff @(posedge sys_clk or posedge sys_reset)
    if (sys_reset) cnt <= '0;
    else cnt <= load ? val - LAG_W'(val != '0) : cnt - LAG_W'(pending);
endmodule

// File: rtl/il_step_sequencer.sv
// il_step_sequencer: run/step/breakpoint controller driving per-domain gated clock enables
module il_step_sequencer
  import il_seq_pkg::*;
#(
  parameter int NUM_DOM = 4,
  parameter int CNT_W = CNT_W_DEF,
  parameter int LAG_W = LAG_W_DEF
) (
  input  logic                     sys_clk,
  input  logic                     sys_reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [CNT_W-1:0]         cmd_arg,
  input  logic [NUM_DOM*LAG_W-1:0] dom_extra,
  output logic [NUM_DOM-1:0]       clk_ce,
  output logic [CNT_W-1:0]         cycle_count,
  output logic                     busy,
  output logic                     break_hit
);
  state_t state, state_nxt;
  logic base_q, base_en, halt, hit, accept, armed, idle_hit;
  logic [CNT_W-1:0] target, remaining, next_count;
  logic [NUM_DOM-1:0] trail_active, trail_left;

  assign cmd_ready = state == S_IDLE || state == S_RUN;
  assign busy = state != S_IDLE;
  assign accept = cmd_valid && cmd_ready;
  assign next_count = cycle_count + CNT_W'(base_q);
  assign hit = armed && next_count == target;
  assign idle_hit = state == S_IDLE && accept && cmd_op == OP_RUN_TO && cmd_arg == next_count;
  assign halt = state == S_RUN ? hit || (accept && cmd_op == OP_STOP) : state == S_STEP && remaining == '0;
  assign base_en = (state == S_RUN || state == S_STEP) && !halt;

  for (genvar d = 0; d < NUM_DOM; d++) begin : g_dom
    il_dom_trail #(.LAG_W(LAG_W)) u_trail (
      .sys_clk(sys_clk),
      .sys_reset(sys_reset),
      .load(halt),
      .val(dom_extra[d*LAG_W +: LAG_W]),
      .trail_active(trail_active[d]),
      .pending(trail_left[d])
    );
  end

  // IDLE dispatches commands, RUN/STEP run until halt, TRAIL drains the trailing enables
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: state_nxt = !accept ? S_IDLE :
                          cmd_op == OP_RUN || (cmd_op == OP_RUN_TO && cmd_arg != next_count) ? S_RUN :
                          cmd_op == OP_STEP && cmd_arg != '0 ? S_STEP : S_IDLE;
      S_RUN, S_STEP: state_nxt = !halt ? state : |dom_extra ? S_TRAIL : S_IDLE;
      default: state_nxt = |trail_left ? S_TRAIL : S_IDLE;
    endcase
  end

  // State, enables, cycle counter, breakpoint and step bookkeeping; a target hit wins over a same-cycle STOP
  always_ff @(posedge sys_clk or posedge sys_reset)
    if (sys_reset) begin
      state <= S_IDLE;
      base_q <= 1'b0;
      clk_ce <= '0;
      cycle_count <= '0;
      break_hit <= 1'b0;
      armed <= 1'b0;
      target <= '0;
      remaining <= '0;
    end else begin
      state <= state_nxt;
      base_q <= base_en;
      clk_ce <= {NUM_DOM{base_en}} | trail_active;
      cycle_count <= next_count;
      break_hit <= (state == S_RUN && hit) || idle_hit;
      if (state == S_IDLE && accept) begin
        armed <= cmd_op == OP_RUN_TO && cmd_arg != next_count;
        target <= cmd_arg;
      end else if (halt) armed <= 1'b0;
      remaining <= state == S_IDLE && accept && cmd_op == OP_STEP ? cmd_arg :
                   remaining - CNT_W'(state == S_STEP && base_en);
    end
endmodule

// File: tb/tb_il_step_sequencer.sv
// tb_il_step_sequencer: directed checks of stepping, running, breakpoints, trails, wrap and reset
module tb_il_step_sequencer;
  import il_seq_pkg::*;
  logic sys_clk = 1'b0, sys_reset = 1'b1, cmd_valid = 1'b0, v8 = 1'b0;
  logic cmd_ready, busy, break_hit, rdy8, busy8, bh8;
  logic [1:0] cmd_op = 2'b00;
  logic [31:0] cmd_arg = '0;
  logic [11:0] dom_extra = '0;
  logic [3:0] clk_ce, ce8, prev_ce = '0;
  logic [31:0] cycle_count, bh_val = '0;
  logic [7:0] cc8, bh8_val = '0;
  int n_err = 0, n_chk = 0;
  int tot_ce[4] = '{default: 0}, tot_rise[4] = '{default: 0};
  int tot_bh = 0, tot_ce8 = 0, tot_bh8 = 0;
  int s_ce[4], s_rise[4], s_bh, s_ce8, s_bh8;
  int exp_t[4];

  always #5 sys_clk = ~sys_clk;

  il_step_sequencer u_dut (
    .sys_clk(sys_clk), .sys_reset(sys_reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .dom_extra(dom_extra), .clk_ce(clk_ce),
    .cycle_count(cycle_count), .busy(busy), .break_hit(break_hit)
  );

  il_step_sequencer #(.CNT_W(8)) u_dut8 (
    .sys_clk(sys_clk), .sys_reset(sys_reset), .cmd_valid(v8), .cmd_ready(rdy8),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg[7:0]), .dom_extra(dom_extra), .clk_ce(ce8),
    .cycle_count(cc8), .busy(busy8), .break_hit(bh8)
  );

  always @(negedge sys_clk) begin
    for (int d = 0; d < 4; d++) begin
      tot_ce[d] += int'(clk_ce[d]);
      tot_rise[d] += int'(clk_ce[d] & ~prev_ce[d]);
    end
    prev_ce = clk_ce;
    tot_ce8 += int'(ce8[0]);
    if (break_hit) begin tot_bh++; bh_val = cycle_count; end
    if (bh8) begin tot_bh8++; bh8_val = cc8; end
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic snap();
    s_ce = tot_ce;
    s_rise = tot_rise;
    s_bh = tot_bh;
    s_ce8 = tot_ce8;
    s_bh8 = tot_bh8;
  endtask

  task automatic do_reset();
    sys_reset = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1 sys_reset = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic send(input bit to8, input logic [1:0] op, input logic [31:0] arg);
    cmd_op = op;
    cmd_arg = arg;
    if (to8) v8 = 1'b1; else cmd_valid = 1'b1;
    @(posedge sys_clk);
    #1 cmd_valid = 1'b0;
    v8 = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || busy8) && n < 1000) begin
      @(posedge sys_clk);
      #1 n++;
    end
    chk({tag, "_timeout"}, longint'(busy || busy8), 0);
    idle(1);
  endtask

  initial begin
    do_reset();
    chk("rst_ce", clk_ce, 0);
    chk("rst_cc", cycle_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bh", break_hit, 0);
    chk("rst_rdy", cmd_ready, 1);
    chk("rst_rdy8", rdy8, 1);

    snap();
    send(0, OP_STEP, 0);
    chk("step0_busy", busy, 0);
    idle(3);
    chk("step0_ce", tot_ce[0] - s_ce[0], 0);

    do_reset();
    snap();
    send(0, OP_STEP, 5);
    chk("s5_ce_first", clk_ce, 0);
    chk("s5_busy", busy, 1);
    chk("s5_rdy", cmd_ready, 0);
    idle(1);
    chk("s5_ce_on", clk_ce, 15);
    wait_idle("s5");
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("s5_n%0d", d), tot_ce[d] - s_ce[d], 5);
      chk($sformatf("s5_rise%0d", d), tot_rise[d] - s_rise[d], 1);
    end
    chk("s5_cc", cycle_count, 5);
    chk("s5_busy_end", busy, 0);

    do_reset();
    dom_extra = {3'd3, 3'd2, 3'd0, 3'd0};
    exp_t = '{1, 1, 3, 4};
    snap();
    send(0, OP_STEP, 1);
    wait_idle("tr");
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("tr_n%0d", d), tot_ce[d] - s_ce[d], exp_t[d]);
      chk($sformatf("tr_rise%0d", d), tot_rise[d] - s_rise[d], 1);
    end
    chk("tr_cc", cycle_count, 1);
    dom_extra = '0;

    do_reset();
    snap();
    send(0, OP_RUN_TO, 100);
    wait_idle("rt");
    chk("rt_ce", tot_ce[0] - s_ce[0], 100);
    chk("rt_bh", tot_bh - s_bh, 1);
    chk("rt_bhval", bh_val, 100);
    chk("rt_cc", cycle_count, 100);
    snap();
    send(0, OP_RUN_TO, 100);
    chk("rt2_busy", busy, 0);
    wait_idle("rt2");
    chk("rt2_bh", tot_bh - s_bh, 1);
    chk("rt2_ce", tot_ce[0] - s_ce[0], 0);
    chk("rt2_cc", cycle_count, 100);

    do_reset();
    snap();
    send(0, OP_RUN, 0);
    idle(10);
    send(0, OP_STEP, 3);
    idle(26);
    send(0, OP_STOP, 0);
    wait_idle("rs");
    chk("rs_ce", tot_ce[0] - s_ce[0], 37);
    chk("rs_rise", tot_rise[0] - s_rise[0], 1);
    chk("rs_cc", cycle_count, 37);
    chk("rs_bh", tot_bh - s_bh, 0);

    do_reset();
    snap();
    send(0, OP_RUN_TO, 10);
    idle(10);
    send(0, OP_STOP, 0);
    wait_idle("hs");
    chk("hs_ce", tot_ce[0] - s_ce[0], 10);
    chk("hs_bh", tot_bh - s_bh, 1);
    chk("hs_bhval", bh_val, 10);
    chk("hs_cc", cycle_count, 10);

    do_reset();
    snap();
    send(1, OP_RUN_TO, 253);
    wait_idle("wp");
    chk("wp_pre_cc", cc8, 253);
    snap();
    send(1, OP_RUN_TO, 2);
    wait_idle("wr");
    chk("wr_ce", tot_ce8 - s_ce8, 5);
    chk("wr_bh", tot_bh8 - s_bh8, 1);
    chk("wr_bhval", bh8_val, 2);
    chk("wr_cc", cc8, 2);

    do_reset();
    send(0, OP_STEP, 50);
    idle(20);
    chk("mr_ce_mid", clk_ce, 15);
    sys_reset = 1'b1;
    #1;
    chk("mr_ce", clk_ce, 0);
    chk("mr_cc", cycle_count, 0);
    chk("mr_busy", busy, 0);
    @(posedge sys_clk);
    #1 sys_reset = 1'b0;
    snap();
    send(0, OP_STEP, 3);
    wait_idle("mr");
    chk("mr_n0", tot_ce[0] - s_ce[0], 3);
    chk("mr_n3", tot_ce[3] - s_ce[3], 3);
    chk("mr_cc3", cycle_count, 3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1);
  end
endmodule
